// File: rtl/tile_fetch_sched.sv
// Tile-map row prefetcher: fills the back bank of a double-buffered line
// store from the shared tile-map RAM and arbitrates CPU writes around it.
module tile_fetch_sched #(
    parameter int unsigned HEIGHT    = 1080,
    parameter int unsigned TILE_SIZE = 40,
    parameter int unsigned MAP_COLS  = 12,
    parameter int unsigned MAP_ROWS  = 27,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_line_start,
    input  logic [15:0]       i_next_line,
    input  logic [3:0]        i_col_idx,
    output logic [31:0]       o_sprite_addr,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    input  logic              i_cpu_wr_req,
    input  logic [ADDR_W-1:0] i_cpu_wr_addr,
    input  logic [31:0]       i_cpu_wr_data,
    output logic              o_cpu_wr_ack,
    output logic              o_fetch_busy,
    output logic              o_fetch_overrun
);

    localparam logic [15:0]       LP_H     = 16'(HEIGHT);
    localparam logic [15:0]       LP_TS    = 16'(TILE_SIZE);
    localparam logic [15:0]       LP_ROWS  = 16'(MAP_ROWS);
    localparam logic [ADDR_W-1:0] LP_COLS_A = ADDR_W'(MAP_COLS);
    localparam logic [3:0]        LP_COLS_C = 4'(MAP_COLS);
    localparam logic [3:0]        LP_LAST  = 4'(MAP_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_col;
    logic [ADDR_W-1:0] r_base;
    logic              r_act;
    logic              r_ovr;
    logic [31:0]       r_bank [2][MAP_COLS];

    logic [15:0]       w_rem;
    logic [15:0]       w_row;
    logic              w_vb_trig;
    logic              w_swap;
    logic              w_has_next;
    logic              w_start;
    logic              w_busy;
    logic [ADDR_W-1:0] w_frow;
    logic [ADDR_W-1:0] w_base;

    assign w_rem      = i_next_line % LP_TS;
    assign w_row      = i_next_line / LP_TS;
    assign w_vb_trig  = i_line_start && (i_next_line == LP_H);
    assign w_swap     = i_line_start && (i_next_line < LP_H) && (w_rem == '0);
    assign w_has_next = (w_row + 16'd1) < LP_ROWS;
    assign w_start    = w_vb_trig || (w_swap && w_has_next);
    assign w_frow     = w_vb_trig ? '0 : ADDR_W'(w_row + 16'd1);
    assign w_base     = w_frow * LP_COLS_A;
    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);

    assign o_fetch_busy    = w_busy;
    assign o_fetch_overrun = r_ovr;

    always_comb begin
        o_sprite_addr = '0;
        if (i_col_idx < LP_COLS_C) begin
            o_sprite_addr = r_bank[r_act][i_col_idx];
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        o_ram_en     = 1'b0;
        o_ram_we     = 1'b0;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        o_cpu_wr_ack = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_start && i_cpu_wr_req) begin
                    o_ram_en     = 1'b1;
                    o_ram_we     = 1'b1;
                    o_ram_addr   = i_cpu_wr_addr;
                    o_ram_wdata  = i_cpu_wr_data;
                    o_cpu_wr_ack = 1'b1;
                    w_state_nx   = S_WRITE;
                end
            end
            S_FETCH: begin
                o_ram_en   = 1'b1;
                o_ram_addr = r_base + ADDR_W'(r_col);
                if (r_col == LP_LAST) begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nx = S_IDLE;
            S_WRITE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        // fetch wins; a swap with no row left aborts any fetch in flight
        if (w_start) begin
            w_state_nx = S_FETCH;
        end else if (w_swap && w_busy) begin
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_base  <= '0;
            r_act   <= 1'b0;
            r_ovr   <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < int'(MAP_COLS); c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_col  <= '0;
                r_base <= w_base;
            end else if (r_state == S_FETCH) begin
                r_col <= r_col + 4'd1;
            end
            // read data lags its address by one cycle
            if ((r_state == S_FETCH) && (r_col != '0)) begin
                r_bank[~r_act][r_col - 4'd1] <= i_ram_rdata;
            end
            if (r_state == S_DRAIN) begin
                r_bank[~r_act][LP_LAST] <= i_ram_rdata;
            end
            if (w_swap) begin
                r_act <= ~r_act;
            end
            if (w_swap && w_busy) begin
                r_ovr <= 1'b1;
            end
        end
    end

endmodule
